// File: rtl/matmul_sel_scheduler.sv
// matmul_sel_scheduler: sequencer for the N x N matrix multiplier datapath.
// Walks C = A x B row-major, driving the A/B operand mux selects, the MAC
// strobes (mac_en/mac_clr) and the C bank write port (c_we/c_addr).
// Ports:
//   clk, rst_n (async, active-low)   clock and reset
//   start                            request a multiply, sampled in IDLE
//   hold                             freeze sequencing (only with MMS_HOLD_EN)
//   sel_a, sel_b                     A-mux select i*N+k, B-mux select k*N+j
//   mac_en, mac_clr                  MAC accumulate / load-product strobes
//   c_we, c_addr                     C bank write strobe and address i*N+j
//   busy, done                       run in progress / one-cycle completion pulse
// Configuration: define MMS_HOLD_EN to add the hold port.
// Every output is a register computed from the current FSM state and indices,
// so each output beat appears one cycle after the state that produces it.

module matmul_sel_scheduler #(
    parameter int N     = 4,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef MMS_HOLD_EN
    input  logic             hold,
`endif
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             c_we,
    output logic [SEL_W-1:0] c_addr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] DIM  = SEL_W'(N);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] i;
    logic [SEL_W-1:0] j;
    logic [SEL_W-1:0] k;
    logic [SEL_W-1:0] i_nx;
    logic [SEL_W-1:0] j_nx;
    logic [SEL_W-1:0] k_nx;

    logic [SEL_W-1:0] sel_a_nx;
    logic [SEL_W-1:0] sel_b_nx;
    logic [SEL_W-1:0] c_addr_nx;
    logic             mac_en_nx;
    logic             mac_clr_nx;
    logic             c_we_nx;
    logic             busy_nx;
    logic             done_nx;

    logic             stall;

`ifdef MMS_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            i     <= i_nx;
            j     <= j_nx;
            k     <= k_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a   <= '0;
            sel_b   <= '0;
            c_addr  <= '0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            c_we    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sel_a   <= sel_a_nx;
            sel_b   <= sel_b_nx;
            c_addr  <= c_addr_nx;
            mac_en  <= mac_en_nx;
            mac_clr <= mac_clr_nx;
            c_we    <= c_we_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        i_nx       = i;
        j_nx       = j;
        k_nx       = k;
        sel_a_nx   = sel_a;
        sel_b_nx   = sel_b;
        c_addr_nx  = c_addr;
        mac_en_nx  = 1'b0;
        mac_clr_nx = 1'b0;
        c_we_nx    = 1'b0;
        busy_nx    = 1'b1;
        done_nx    = 1'b0;

        unique case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx = ACC;
                    i_nx     = '0;
                    j_nx     = '0;
                    k_nx     = '0;
                    busy_nx  = 1'b1;
                end
            end

            ACC: begin
                // A stalled beat emits no strobes and keeps the selects.
                if (!stall) begin
                    mac_en_nx  = 1'b1;
                    mac_clr_nx = (k == '0);
                    sel_a_nx   = i * DIM + k;
                    sel_b_nx   = k * DIM + j;
                    if (k == LAST) begin
                        state_nx = WRITE;
                    end else begin
                        k_nx = k + 1'b1;
                    end
                end
            end

            WRITE: begin
                if (!stall) begin
                    c_we_nx   = 1'b1;
                    c_addr_nx = i * DIM + j;
                    k_nx      = '0;
                    if (i == LAST && j == LAST) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = ACC;
                        if (j == LAST) begin
                            j_nx = '0;
                            i_nx = i + 1'b1;
                        end else begin
                            j_nx = j + 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_sel_scheduler.sv
// tb_matmul_sel_scheduler: randomized self-checking bench for matmul_sel_scheduler.
// Reference: beat schedule from the timing rules plus an A x B product model.

module tb_matmul_sel_scheduler;

    localparam int N     = 4;
    localparam int SEL_W = 4;
    localparam int NN    = N * N;
    localparam int TOT   = NN * (N + 1);

`ifdef MMS_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             hold  = 1'b0;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] c_addr;
    logic             mac_en;
    logic             mac_clr;
    logic             c_we;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [15:0]      a_mem [NN];
    logic [15:0]      b_mem [NN];
    longint           c_mem [NN];
    longint           c_ref [NN];
    longint           acc;
    logic [SEL_W-1:0] m_sa = '0;
    logic [SEL_W-1:0] m_sb = '0;
    logic [SEL_W-1:0] m_ca = '0;
    int               tr_a [N] = '{4, 5, 6, 7};
    int               tr_b [N] = '{2, 6, 10, 14};

    always #5 clk = ~clk;

    matmul_sel_scheduler #(.N(N), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef MMS_HOLD_EN
        .hold    (hold),
`endif
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .mac_en  (mac_en),
        .mac_clr (mac_clr),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".sel_a"}, sel_a, 0);
        chk({tag, ".sel_b"}, sel_b, 0);
        chk({tag, ".c_addr"}, c_addr, 0);
        chk({tag, ".mac_en"}, mac_en, 0);
        chk({tag, ".mac_clr"}, mac_clr, 0);
        chk({tag, ".c_we"}, c_we, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    task automatic load_mats(input bit ident);
        for (int x = 0; x < NN; x++) begin
            if (ident) begin
                a_mem[x] = ((x / N) == (x % N)) ? 16'd1 : 16'd0;
                b_mem[x] = 16'(x + 1);
            end else begin
                a_mem[x] = 16'($urandom_range(0, 65535));
                b_mem[x] = 16'($urandom_range(0, 65535));
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                c_ref[r*N+c] = 0;
                for (int m = 0; m < N; m++) begin
                    c_ref[r*N+c] += longint'(a_mem[r*N+m]) *
                                    longint'(b_mem[m*N+c]);
                end
            end
        end
    endtask

    task automatic do_abort();
        #2 rst_n = 1'b0;
        #1;
        m_sa = '0;
        m_sb = '0;
        m_ca = '0;
        chk_idle_zero("abort");
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("abort_done@%0d", n), done, 0);
            chk($sformatf("abort_we@%0d", n), c_we, 0);
        end
        start = 1'b0;
        hold  = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk($sformatf("post_abort_busy@%0d", n), busy, 0);
        end
    endtask

    task automatic run(input int hold_from, input int hold_len, input int p1,
                       input int p2, input bit tail, input int abort_at);
        int   beat;
        int   ndone;
        int   dcyc;
        int   p;
        int   e;
        logic held;
        logic e_en;
        logic e_clr;
        logic e_we;
        logic e_busy;
        logic e_done;
        beat  = 0;
        ndone = 0;
        dcyc  = -1;
        acc   = 0;
        for (int x = 0; x < NN; x++) c_mem[x] = -1;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy@0", busy, 1);
        chk("mac_en@0", mac_en, 0);

        for (int t = 1; t <= TOT + hold_len + 4; t++) begin
            start = (t == p1) || (t == p2) ||
                    (tail && t >= TOT - 2 && t <= TOT + 1);
            hold  = (t >= hold_from) && (t < hold_from + hold_len);
            if (t == abort_at) begin
                do_abort();
                return;
            end
            @(posedge clk);
            @(negedge clk);

            held   = HOLD_EN && hold && (beat < TOT);
            e_en   = 1'b0;
            e_clr  = 1'b0;
            e_we   = 1'b0;
            e_done = 1'b0;
            e_busy = 1'b1;
            if (beat < TOT && !held) begin
                p = beat % (N + 1);
                e = beat / (N + 1);
                if (p < N) begin
                    e_en  = 1'b1;
                    e_clr = (p == 0);
                    m_sa  = SEL_W'((e / N) * N + p);
                    m_sb  = SEL_W'(p * N + e % N);
                    if (e == 6) begin
                        chk($sformatf("trace_sel_a@%0d", p), sel_a, tr_a[p]);
                        chk($sformatf("trace_sel_b@%0d", p), sel_b, tr_b[p]);
                    end
                end else begin
                    e_we = 1'b1;
                    m_ca = SEL_W'(e);
                    if (e == 6) chk("trace_c_addr", c_addr, 6);
                end
                beat++;
            end else if (beat == TOT) begin
                e_done = 1'b1;
                beat++;
            end else if (beat > TOT) begin
                e_busy = 1'b0;
            end

            chk($sformatf("mac_en@%0d", t), mac_en, e_en);
            chk($sformatf("mac_clr@%0d", t), mac_clr, e_clr);
            chk($sformatf("c_we@%0d", t), c_we, e_we);
            chk($sformatf("busy@%0d", t), busy, e_busy);
            chk($sformatf("done@%0d", t), done, e_done);
            chk($sformatf("sel_a@%0d", t), sel_a, m_sa);
            chk($sformatf("sel_b@%0d", t), sel_b, m_sb);
            chk($sformatf("c_addr@%0d", t), c_addr, m_ca);

            if (mac_en === 1'b1) begin
                acc = (mac_clr === 1'b1 ? 0 : acc) +
                      longint'(a_mem[sel_a]) * longint'(b_mem[sel_b]);
            end
            if (c_we === 1'b1) c_mem[c_addr] = acc;
            if (done === 1'b1) begin
                ndone++;
                if (dcyc < 0) dcyc = t;
            end
            if (!e_busy) break;
        end
        start = 1'b0;
        hold  = 1'b0;

        chk("done_count", ndone, 1);
        chk("done_cycle", dcyc, TOT + 1 + hold_len);
        for (int x = 0; x < NN; x++) begin
            chk($sformatf("c[%0d]", x), c_mem[x], c_ref[x]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        hold  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("idle_busy@%0d", n), busy, 0);
            chk($sformatf("idle_mac_en@%0d", n), mac_en, 0);
        end

        load_mats(1'b1);
        run(0, 0, 0, 0, 1'b0, 0);

        load_mats(1'b0);
        run(0, 0, 10, 50, 1'b1, 0);

        load_mats(1'b0);
        run(0, 0, 0, 0, 1'b0, 40);

        load_mats(1'b0);
        run(0, 0, $urandom_range(1, TOT - 4), 0, 1'b0, 0);

        if (HOLD_EN) begin
            load_mats(1'b1);
            run(3, 5, 0, 0, 1'b0, 0);
            load_mats(1'b0);
            run(int'($urandom_range(0, NN - 1)) * (N + 1) + 3,
                int'($urandom_range(1, 6)), 0, 0, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
